// File: rtl/pixel_writer.sv
// pixel_writer: captures one frame of streamed pixels into a frame buffer in raster order,
// one write per accepted pixel with a single cycle of latency.
module pixel_writer #(
    parameter int IMG_WIDTH  = 220,
    parameter int IMG_HEIGHT = 220,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [15:0]           col,
    output logic [15:0]           row,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  accept;
    logic                  last;

    assign in_ready = state == RUN;
    assign busy     = state == RUN;
    assign accept   = in_valid && in_ready;
    assign last     = cnt == ADDR_WIDTH'(TOTAL - 1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            col      <= '0;
            row      <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            we   <= accept;
            done <= accept && last;
            if (accept) begin
                waddr <= cnt;
                wdata <= in_data;
                cnt   <= cnt + ADDR_WIDTH'(1);
            end
            // a pixel offered while not ready is dropped; flagging it wins over a clearing start
            if (in_valid && !in_ready)
                overflow <= 1'b1;
            else if (state == IDLE && start)
                overflow <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    cnt   <= '0;
                    col   <= '0;
                    row   <= '0;
                end
                RUN: if (accept) begin
                    if (last) begin
                        state <= FIN;
                        col   <= '0;
                        row   <= '0;
                    end else if (col == 16'(IMG_WIDTH - 1)) begin
                        col <= '0;
                        row <= row + 16'd1;
                    end else begin
                        col <= col + 16'd1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: small 4x3 instance checked every cycle against a frame-level model,
// plus a default-size instance streamed through one full frame.
module tb_pixel_writer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int BN = 220 * 220;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, start, in_valid, in_ready, we, busy, done, overflow;
    logic [7:0]  in_data, wdata;
    logic [15:0] waddr, col, row;

    logic        b_rstn, b_start, b_valid, b_ready, b_we, b_busy, b_done, b_ovf;
    logic [7:0]  b_data, b_wdata;
    logic [15:0] b_waddr, b_col, b_row;

    pixel_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .col(col), .row(row),
        .busy(busy), .done(done), .overflow(overflow)
    );

    pixel_writer dut_big (
        .clk(clk), .rstn(b_rstn), .start(b_start), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .col(b_col), .row(b_row),
        .busy(b_busy), .done(b_done), .overflow(b_ovf)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // frame-level model: phase 0 idle, 1 capturing, 2 frame finished; row/col derive from the pixel count
    int          m_phase = 0, m_cnt = 0;
    bit          m_we = 0, m_done = 0, m_ovf = 0, m_live = 0;
    logic [15:0] m_waddr = '0;
    logic [7:0]  m_wdata = '0;

    always @(posedge clk) begin
        bit acc;
        acc = in_valid && m_phase == 1;
        if (!rstn) begin
            m_phase = 0; m_cnt = 0; m_we = 0; m_done = 0; m_ovf = 0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_we   = acc;
            m_done = acc && m_cnt == N - 1;
            if (acc) begin
                m_waddr = 16'(m_cnt);
                m_wdata = in_data;
            end
            m_ovf = (in_valid && m_phase != 1) || (m_ovf && !(m_phase == 0 && start));
            if (m_phase == 0 && start) begin
                m_phase = 1;
                m_cnt   = 0;
            end else if (m_phase == 2) begin
                m_phase = 0;
            end else if (acc) begin
                m_cnt++;
                if (m_cnt == N) m_phase = 2;
            end
        end
        m_live = 1;
    end

    int nwrites = 0, ndones = 0;

    always @(negedge clk) if (m_live) begin
        chk("cycle_outputs",
            {in_ready, busy, we, done, overflow, waddr, wdata, col, row},
            {m_phase == 1, m_phase == 1, m_we, m_done, m_ovf, m_waddr, m_wdata,
             16'(m_cnt % W), 16'((m_cnt / W) % H)});
        if (we) nwrites++;
        if (done) ndones++;
    end

    int b_dones = 0, b_last = -1, b_max = 0;
    bit b_fin = 0;

    always @(negedge clk) begin
        if (b_we && int'(b_waddr) > b_max) b_max = int'(b_waddr);
        if (b_done) begin
            b_dones++;
            b_last = b_we ? int'(b_waddr) : -1;
        end
    end

    initial begin
        b_rstn = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_data = '0;
        repeat (2) @(negedge clk);
        b_rstn = 1'b1; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < BN; i++) begin
            b_valid = 1'b1;
            b_data  = 8'($urandom);
            @(negedge clk);
        end
        b_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("big_done_count", b_dones, 1);
        chk("big_last_addr", b_last, BN - 1);
        chk("big_max_addr", b_max, BN - 1);
        chk("big_ready_low", b_ready, 0);
        b_fin = 1;
    end

    initial begin
        int nw0, nd0;
        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", in_ready, 0);
        chk("reset_waddr", waddr, 0);
        chk("reset_ovf", overflow, 0);
        rstn = 1'b1;

        // back-to-back frame 0x10..0x1B
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            @(negedge clk);
            chk("b2b_write", {we, waddr, wdata}, {1'b1, 16'(i), 8'(8'h10 + i)});
        end
        chk("b2b_done", done, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_ready_after", in_ready, 0);
        chk("b2b_done_after", done, 0);

        // frame with 1-3 cycle gaps
        nw0 = nwrites;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            if (i == 5) begin
                chk("row_at_5", row, 1);
                chk("col_at_5", col, 1);
            end
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("gap_writes", nwrites - nw0, N);

        // pixel offered while idle
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_ovf_set", overflow, 1);
        chk("idle_no_write", we, 0);
        @(negedge clk);
        chk("ovf_sticky", overflow, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // reset after 7 pixels, then restart
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            @(negedge clk);
        end
        rstn = 1'b0;
        @(negedge clk);
        chk("midframe_reset",
            {in_ready, busy, we, done, overflow, waddr, wdata, col, row}, 0);
        rstn = 1'b1; in_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        chk("restart_write", {we, waddr, wdata}, {1'b1, 16'd0, 8'hA5});

        // start held high for a whole frame
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; start = 1'b1;
        @(negedge clk);
        nd0 = ndones;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("held_done", done, 1);
        @(negedge clk);
        chk("held_idle_gap", busy, 0);
        @(negedge clk);
        chk("held_rearm", busy, 1);
        chk("held_done_count", ndones - nd0, 1);
        start = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            rstn     = $urandom_range(0, 199) != 0;
            start    = $urandom_range(0, 9) == 0;
            in_valid = $urandom_range(0, 3) != 0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        rstn = 1'b1; start = 1'b0; in_valid = 1'b0;

        for (int k = 0; k < 60000 && !b_fin; k++) @(negedge clk);
        chk("big_finished", b_fin, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
- REQ-001: The block SHALL have parameter IMG_WIDTH, default 220, pixels per row.
- REQ-002: The block SHALL have parameter IMG_HEIGHT, default 220, rows per frame.
- REQ-003: The block SHALL have parameter ADDR_WIDTH, default 16, frame-buffer address width.
- REQ-004: The block SHALL have parameter DATA_WIDTH, default 8, pixel width.
- REQ-005: The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-006: The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
- REQ-007: The block SHALL have port start, input, 1 bit: arms capture of one frame.
- REQ-008: The block SHALL have port in_valid, input, 1 bit: the upstream pixel is valid.
- REQ-009: The block SHALL have port in_data, input, DATA_WIDTH bits: the upstream pixel value.
- REQ-010: The block SHALL have port in_ready, output, 1 bit: the block accepts a pixel this cycle.
- REQ-011: The block SHALL have port we, output, 1 bit: frame-buffer write enable.
- REQ-012: The block SHALL have port waddr, output, ADDR_WIDTH bits: frame-buffer write address.
- REQ-013: The block SHALL have port wdata, output, DATA_WIDTH bits: frame-buffer write data.
- REQ-014: The block SHALL have port col, output, 16 bits: column of the next pixel to be accepted.
- REQ-015: The block SHALL have port row, output, 16 bits: row of the next pixel to be accepted.
- REQ-016: The block SHALL have port busy, output, 1 bit: high while in RUN.
- REQ-017: The block SHALL have port done, output, 1 bit: one-cycle pulse when the frame is complete.
- REQ-018: The block SHALL have port overflow, output, 1 bit: sticky error flag.

Function
- REQ-019: The FSM SHALL have states IDLE, RUN and FIN; any illegal state SHALL go to IDLE.
- REQ-020: in_ready and busy SHALL be decoded from the state register only, high exactly when the state is RUN; there is no combinational path from in_valid.
- REQ-021: Accept condition: in_valid && in_ready.
- REQ-022: In IDLE, when start=1: cnt, col and row <= 0; overflow <= 0; state <= RUN.
- REQ-023: In RUN, start SHALL be ignored.
- REQ-024: On each accept, the next cycle SHALL give we=1, waddr = cnt at acceptance, and wdata = in_data at acceptance (1-cycle latency).
- REQ-025: On each accept, cnt SHALL increment by 1.
- REQ-026: On each accept, col SHALL increment; at col == IMG_WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
- REQ-027: we SHALL be 0 in every cycle that follows a cycle without an accept.
- REQ-028: waddr and wdata SHALL hold their last values when we=0.
- REQ-029: Accepting the pixel at cnt == IMG_WIDTH*IMG_HEIGHT-1 SHALL move the state to FIN; in_ready SHALL be 0 from the next cycle, and row/col SHALL wrap to 0/0.
- REQ-030: In FIN: done=1 for exactly that one cycle, then state <= IDLE.
- REQ-031: The last write (we=1) SHALL coincide with the done cycle.
- REQ-032: in_valid=1 while in_ready=0 (IDLE or FIN) SHALL set overflow=1.
- REQ-033: overflow SHALL stay set until rstn or the next accepted start; the offending pixel SHALL be dropped and not written.
- REQ-034: start in the same cycle as FIN SHALL be ignored; start is sampled only in IDLE.
- REQ-035: Stalls (in_valid=0 in RUN) SHALL hold cnt/row/col and generate no write; there is no timeout.
- REQ-036: cnt SHALL be ADDR_WIDTH bits; IMG_WIDTH*IMG_HEIGHT SHALL be <= 2^ADDR_WIDTH, and waddr SHALL never exceed IMG_WIDTH*IMG_HEIGHT-1.

Reset
- REQ-037: With rstn=0 at a clock edge: state=IDLE, cnt=0, col=0, row=0, we=0, waddr=0, wdata=0, done=0, overflow=0, busy=0, in_ready=0.
- REQ-038: Reset SHALL take effect at the next edge in any state, including mid-frame; the partial frame is abandoned and no done pulse is issued.
- REQ-039: Reset SHALL have priority over start and in_valid.

Verification
- REQ-040: W=4, H=3; start, then 12 back-to-back valid pixels 0x10..0x1B -> writes to addr 0..11 with matching data, one per cycle; done=1 in the same cycle as the addr-11 write; in_ready=0 afterwards.
- REQ-041: W=4, H=3 with in_valid gaps of 1-3 cycles -> we only follows accepts; row/col at pixel 5 = 1/1; total of exactly 12 writes.
- REQ-042: in_valid=1 while IDLE -> overflow=1 and no write; a subsequent start clears overflow.
- REQ-043: rstn=0 after 7 pixels -> all outputs at reset values next cycle and no done; a new start rewrites from addr 0.
- REQ-044: start held high through an entire frame -> exactly one frame captured; after FIN a second frame begins on the first IDLE cycle with start=1.
- REQ-045: Defaults 220x220 -> last write at addr 48399, done pulses once, and waddr never exceeds 48399.
